mul_share_sched: RTL and testbench
==================================

Name: mul_share_sched

Overview:
- Scheduler and controller that shares one repeated-addition multiplier datapath (A reg, B down-counter, P accumulator, eqz flag) between two requesters.
- Arbitrates requests round-robin and latches the winner's operands.
- Sequences the datapath through load/add/decrement steps by driving its control strobes.
- Returns the product to the winning requester with a one-cycle response pulse.
- Sits between the two client blocks and the shared multiplier datapath; replaces the single-client controller.

Parameters:
- WIDTH, 16, operand, bus and result width in bits.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  2  bit i set: requester i has a job pending. Held until the matching req_ready.
- req_a0  input  WIDTH  multiplicand, requester 0.
- req_b0  input  WIDTH  multiplier (repeat count), requester 0.
- req_a1  input  WIDTH  multiplicand, requester 1.
- req_b1  input  WIDTH  multiplier, requester 1.
- req_ready  output  2  one-hot one-cycle accept pulse.
- resp_valid  output  2  one-hot one-cycle completion pulse to the owner.
- resp_result  output  WIDTH  product; valid while resp_valid is nonzero, held otherwise.
- busy  output  1  high whenever state is not IDLE.
- owner  output  1  index of the requester currently being served.
- dp_data_in  output  WIDTH  operand bus to the datapath.
- dp_ld_a  output  1  load A from bus.
- dp_ld_b  output  1  load B from bus.
- dp_clr_p  output  1  clear P to 0.
- dp_ld_p  output  1  P <= P + A.
- dp_dec_b  output  1  B <= B - 1.
- dp_eqz  input  1  combinational (B == 0) from the datapath.
- dp_result  input  WIDTH  P register value.

Behaviour:
- Reset (async, rst_n low):
  - State is IDLE; all dp_* strobes, req_ready and resp_valid are 0.
  - resp_result, dp_data_in and the operand latches are 0; busy is 0; owner is 0.
  - The round-robin pointer (last_served) is 1, so requester 0 wins the first tie.
- States: IDLE, LOAD_A, LOAD_B, ADD, DONE. All outputs are registered or decoded from state only; no combinational path from req_valid to strobes.
- IDLE:
  - With a single req_valid bit set, grant that requester.
  - With both set, grant !last_served.
  - On grant, in the same cycle:
    - pulse req_ready[i];
    - latch req_a_i and req_b_i into internal registers;
    - set owner = i and last_served = i;
    - next state is LOAD_A.
  - With no request, stay in IDLE.
- LOAD_A: dp_data_in = latched A; dp_ld_a = 1; next state is LOAD_B.
- LOAD_B: dp_data_in = latched B; dp_ld_b = 1; dp_clr_p = 1; next state is ADD.
- ADD:
  - If dp_eqz = 1: no strobes; next state is DONE.
  - Otherwise: dp_ld_p = 1 and dp_dec_b = 1; stay in ADD.
  - ADD occupies b+1 cycles, so b = 0 produces no additions.
- DONE:
  - Register resp_result = dp_result and pulse resp_valid[owner] for one cycle.
  - Next state is IDLE. A new grant is possible on the following cycle, never in DONE itself.
- Latency: from the req_ready edge to the resp_valid edge is b+4 cycles.
- Arithmetic: the product is modulo 2^WIDTH (datapath accumulator wraps); no overflow flag.
- dp_data_in outside LOAD_A/LOAD_B holds its last value; the datapath ignores it.
- Requests arriving while busy:
  - req_ready stays 0; the request waits.
  - Operand changes on the pending requester do not affect the job in flight.
- Fairness: with both requesting continuously, grants alternate 0,1,0,1…; neither requester waits more than one job.
- Async reset in any state: abort immediately to the reset values above. The in-flight job produces no response; its requester must re-request.
- No simultaneous grant and response: resp_valid and req_ready are never high in the same cycle.

Test Plan:
- Single request, no contention: req0 with a=17, b=5 → req_ready=01 one cycle; 5 cycles with ld_p/dec_b; resp_valid=01 exactly 9 cycles after accept; resp_result=85.
- Zero multiplier: req1 with a=1234, b=0 → dp_ld_p never asserted; resp_valid=10 after 4 cycles; resp_result=0.
- Simultaneous requests after reset: req0 (3,4) and req1 (6,7) both set → req0 served first with result 12. req1 is accepted the cycle after DONE with result 42. A third back-to-back pair is granted 0 then 1 again.
- Overflow wrap: a=300, b=300 → resp_result=24464 (90000 mod 65536); latency 304 cycles.
- Reset mid-ADD: req0 (10,50), assert rst_n=0 at the 20th ADD cycle → all strobes and busy drop asynchronously; no resp_valid ever appears. After release, req1 (2,3) is granted first? No: the pointer resets to 1, so a tie goes to 0. With req1 alone, it is granted and returns 6.
- Request during busy: req1 raised while req0 (5,2) runs → req_ready[1] stays 0 until the cycle after DONE. req1's operands, changed while waiting, are taken at grant time.

Source files
------------

// File: rtl/mul_share_sched.sv
// Shares one repeated-addition multiplier datapath between two requesters:
// round-robin arbitration, operand capture, datapath sequencing, response return.
module mul_share_sched #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  output logic [1:0]       req_ready,
  output logic [1:0]       resp_valid,
  output logic [WIDTH-1:0] resp_result,
  output logic             busy,
  output logic             owner,
  output logic [WIDTH-1:0] dp_data_in,
  output logic             dp_ld_a,
  output logic             dp_ld_b,
  output logic             dp_clr_p,
  output logic             dp_ld_p,
  output logic             dp_dec_b,
  input  logic             dp_eqz,
  input  logic [WIDTH-1:0] dp_result
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_ADD    = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t           state;
  state_t           state_d;
  logic             grant;
  logic             grant_idx;
  logic             last_served;
  logic [WIDTH-1:0] b_lat;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state, arbitration and datapath strobes decoded from state
  always_comb begin
    state_d   = state;
    grant     = 1'b0;
    grant_idx = 1'b0;
    busy      = 1'b1;
    dp_ld_a   = 1'b0;
    dp_ld_b   = 1'b0;
    dp_clr_p  = 1'b0;
    dp_ld_p   = 1'b0;
    dp_dec_b  = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (req_valid != 2'b00) begin
          grant     = 1'b1;
          grant_idx = (req_valid == 2'b11) ? ~last_served : req_valid[1];
          state_d   = S_LOAD_A;
        end
      end
      S_LOAD_A: begin
        dp_ld_a = 1'b1;
        state_d = S_LOAD_B;
      end
      S_LOAD_B: begin
        dp_ld_b  = 1'b1;
        dp_clr_p = 1'b1;
        state_d  = S_ADD;
      end
      S_ADD: begin
        if (dp_eqz) begin
          state_d = S_DONE;
        end else begin
          dp_ld_p  = 1'b1;
          dp_dec_b = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Grant capture: accept pulse, operand latch, owner and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready   <= 2'b00;
      owner       <= 1'b0;
      last_served <= 1'b1;
      b_lat       <= '0;
      dp_data_in  <= '0;
    end else begin
      req_ready <= grant ? 2'(2'b01 << grant_idx) : 2'b00;
      if (grant) begin
        owner       <= grant_idx;
        last_served <= grant_idx;
        b_lat       <= grant_idx ? req_b1 : req_b0;
        // Multiplicand goes straight onto the bus for the LOAD_A cycle
        dp_data_in  <= grant_idx ? req_a1 : req_a0;
      end else if (state == S_LOAD_A) begin
        dp_data_in  <= b_lat;
      end
    end
  end

  // Response: product captured when leaving DONE, pulsed to the owner
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid  <= 2'b00;
      resp_result <= '0;
    end else begin
      resp_valid <= (state == S_DONE) ? 2'(2'b01 << owner) : 2'b00;
      if (state == S_DONE) begin
        resp_result <= dp_result;
      end
    end
  end

endmodule

// File: tb/tb_mul_share_sched.sv
// Bench for mul_share_sched with a behavioural shared datapath and a
// grant/response scoreboard.
module tb_mul_share_sched;

  localparam int unsigned WIDTH = 16;

  logic             clk;
  logic             rst_n;
  logic [1:0]       req_valid;
  logic [WIDTH-1:0] op_a [2];
  logic [WIDTH-1:0] op_b [2];
  logic [1:0]       req_ready;
  logic [1:0]       resp_valid;
  logic [WIDTH-1:0] resp_result;
  logic             busy;
  logic             owner;
  logic [WIDTH-1:0] dp_data_in;
  logic             dp_ld_a, dp_ld_b, dp_clr_p, dp_ld_p, dp_dec_b;
  logic             dp_eqz;
  logic [WIDTH-1:0] dp_result;

  logic [WIDTH-1:0] reg_a, reg_b, reg_p;

  mul_share_sched #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid),
    .req_a0(op_a[0]), .req_b0(op_b[0]),
    .req_a1(op_a[1]), .req_b1(op_b[1]),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_result(resp_result),
    .busy(busy), .owner(owner),
    .dp_data_in(dp_data_in),
    .dp_ld_a(dp_ld_a), .dp_ld_b(dp_ld_b), .dp_clr_p(dp_clr_p),
    .dp_ld_p(dp_ld_p), .dp_dec_b(dp_dec_b),
    .dp_eqz(dp_eqz), .dp_result(dp_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared repeated-addition datapath
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_a <= '0;
      reg_b <= '0;
      reg_p <= '0;
    end else begin
      if (dp_ld_a) reg_a <= dp_data_in;
      if (dp_ld_b) reg_b <= dp_data_in;
      else if (dp_dec_b) reg_b <= reg_b - WIDTH'(1);
      if (dp_clr_p) reg_p <= '0;
      else if (dp_ld_p) reg_p <= reg_p + reg_a;
    end
  end
  assign dp_eqz    = (reg_b == '0);
  assign dp_result = reg_p;

  typedef struct {
    int               idx;
    logic [WIDTH-1:0] exp;
    int               b;
    int               gcyc;
  } job_t;

  int   gq[$];
  job_t rq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   ldp_cnt = 0;
  int   in_flight = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic raise(input int idx, input int a, input int b);
    op_a[idx] = WIDTH'(a);
    op_b[idx] = WIDTH'(b);
    req_valid[idx] = 1'b1;
    gq.push_back(idx);
  endtask

  // One clock; scoreboard bookkeeping on grants and responses
  task automatic step();
    job_t        j;
    int          idx;
    int unsigned prod;
    @(posedge clk);
    #1;
    cyc++;
    if (dp_ld_p) ldp_cnt++;
    if (req_ready != 2'b00) begin
      chk("grant_when_idle", 64'(in_flight), 64'd0);
      chk("grant_no_resp", 64'(resp_valid), 64'd0);
      chk("grant_expected", 64'(gq.size() != 0), 64'd1);
      if (gq.size() != 0) begin
        idx = gq.pop_front();
        chk("req_ready", 64'(req_ready), 64'(2'b01 << idx));
        chk("owner", 64'(owner), 64'(idx));
        prod  = 32'(op_a[idx]) * 32'(op_b[idx]);
        j.idx  = idx;
        j.exp  = WIDTH'(prod);
        j.b    = int'(op_b[idx]);
        j.gcyc = cyc;
        rq.push_back(j);
        in_flight = 1;
        ldp_cnt   = 0;
        req_valid[idx] = 1'b0;
        op_a[idx] = WIDTH'($urandom);
        op_b[idx] = WIDTH'($urandom);
      end
    end
    if (resp_valid != 2'b00) begin
      chk("resp_expected", 64'(rq.size() != 0), 64'd1);
      if (rq.size() != 0) begin
        j = rq.pop_front();
        chk("resp_valid", 64'(resp_valid), 64'(2'b01 << j.idx));
        chk("resp_result", 64'(resp_result), 64'(j.exp));
        chk("latency", 64'(cyc - j.gcyc), 64'(j.b + 4));
        chk("add_cycles", 64'(ldp_cnt), 64'(j.b));
        in_flight = 0;
      end
    end
  endtask

  task automatic wait_done(input string tag, input int max);
    int n = 0;
    while ((gq.size() != 0 || rq.size() != 0 || busy) && n < max) begin
      step();
      n++;
    end
    chk({"timeout_", tag}, 64'(n >= max), 64'd0);
  endtask

  initial begin
    int n;
    rst_n     = 1'b0;
    req_valid = 2'b00;
    op_a[0] = '0; op_b[0] = '0; op_a[1] = '0; op_b[1] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_owner", 64'(owner), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_result", 64'(resp_result), 64'd0);
    chk("rst_data_in", 64'(dp_data_in), 64'd0);
    chk("rst_strobes", 64'({dp_ld_a, dp_ld_b, dp_clr_p, dp_ld_p, dp_dec_b}), 64'd0);
    rst_n = 1'b1;
    repeat (2) step();
    chk("idle_busy", 64'(busy), 64'd0);

    // Single request and zero multiplier
    raise(0, 17, 5);
    wait_done("single", 50);
    raise(1, 1234, 0);
    wait_done("zero_b", 50);

    // Contention: two back-to-back tie pairs
    raise(0, 3, 4);
    raise(1, 6, 7);
    wait_done("tie1", 100);
    raise(0, 100, 200);
    raise(1, 65535, 2);
    wait_done("tie2", 600);

    // Wrapping product
    raise(0, 300, 300);
    wait_done("wrap", 400);

    // Request while busy; waiting operands change before grant
    raise(0, 5, 2);
    n = 0;
    while (in_flight == 0 && n < 20) begin step(); n++; end
    chk("busy_grant0_seen", 64'(in_flight), 64'd1);
    raise(1, 9, 9);
    repeat (2) step();
    op_a[1] = WIDTH'(7);
    op_b[1] = WIDTH'(3);
    wait_done("busy_req", 100);

    // Asynchronous reset in the middle of ADD
    raise(0, 10, 50);
    n = 0;
    while (ldp_cnt < 20 && n < 100) begin step(); n++; end
    chk("mid_add_reached", 64'(ldp_cnt), 64'd20);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_strobes", 64'({dp_ld_a, dp_ld_b, dp_clr_p, dp_ld_p, dp_dec_b}), 64'd0);
    chk("abort_owner", 64'(owner), 64'd0);
    chk("abort_resp_valid", 64'(resp_valid), 64'd0);
    req_valid = 2'b00;
    gq.delete();
    rq.delete();
    in_flight = 0;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (70) step();
    chk("abort_idle", 64'(busy), 64'd0);
    raise(1, 2, 3);
    wait_done("post_rst", 50);
    raise(0, 4, 5);
    raise(1, 6, 7);
    wait_done("post_rst_tie", 100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
